// File: rtl/rw_pkg.sv
// Shared types for the Sobel-to-SRAM read/write arbiter.
package rw_pkg;

  typedef enum logic [1:0] {
    INSTR_IDLE  = 2'b00,
    INSTR_READ  = 2'b01,
    INSTR_WRITE = 2'b10
  } mem_instr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT,
    DONE
  } rw_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping to the lowest index.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gnt_vld && req[i] && (i >= int'(ptr))) begin
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
        gnt_vld = 1'b1;
      end
    end
    // Nothing at or above the pointer: wrap around to the lowest requester.
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gnt_vld && req[i]) begin
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_rw_arbiter.sv
// Multi-channel read/write port in front of the pixel SRAM controller; one command in flight at a time.
module mem_rw_arbiter
  import rw_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NUM_CH = 2,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [DATA_W-1:0]        ch_rdata,
  input  logic                     mem_busy,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [1:0]               mem_instr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  rw_state_t         state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [NUM_CH-1:0] gnt_oh_q, gnt_oh_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_instr_t        instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_CH-1:0] done_q, done_d;

  logic [NUM_CH-1:0] req_eff;
  logic [NUM_CH-1:0] arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_vld;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  // A requester still sees its own done pulse this cycle; keep it from being re-granted.
  assign req_eff = ch_req & ~done_q;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req     (req_eff),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    we_sel    = |(ch_we & arb_gnt);
    addr_sel  = '0;
    wdata_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_gnt[i]) begin
        addr_sel  = ch_addr[i*ADDR_W +: ADDR_W];
        wdata_sel = ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_oh_d  = gnt_oh_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    instr_d   = INSTR_IDLE;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    done_d    = '0;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          gnt_idx_d = arb_idx;
          gnt_oh_d  = arb_gnt;
          we_d      = we_sel;
          addr_d    = addr_sel;
          wdata_d   = wdata_sel;
          instr_d   = we_sel ? INSTR_WRITE : INSTR_READ;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_busy) begin
          // Withdrawal only counts before acceptance; an idle-busy cycle always accepts.
          if (|(ch_req & gnt_oh_q)) begin
            instr_d = instr_q;
          end else begin
            state_d = IDLE;
          end
        end else if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        done_d  = gnt_oh_q;
        ptr_d   = (int'(gnt_idx_q) == NUM_CH - 1) ? '0 : gnt_idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      instr_q   <= INSTR_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_oh_q  <= gnt_oh_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
    end
  end

  assign mem_instr = instr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ch_rdata  = rdata_q;
  assign ch_done   = done_q;

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Bench for mem_rw_arbiter (2 channels, RD_LAT=2): vector table plus hand-written corner sequences.
module tb_mem_rw_arbiter;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int NUM_CH = 2;
  localparam int RD_LAT = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_we;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_done;
  logic [DATA_W-1:0]        ch_rdata;
  logic                     mem_busy;
  logic [DATA_W-1:0]        mem_rdata;
  logic [1:0]               mem_instr;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;

  mem_rw_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_CH (NUM_CH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_req    (ch_req),
    .ch_we     (ch_we),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_done   (ch_done),
    .ch_rdata  (ch_rdata),
    .mem_busy  (mem_busy),
    .mem_rdata (mem_rdata),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         busy;
    logic [1:0] exp_instr;
    logic [1:0] exp_done;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic [1:0] done;
    logic [7:0] rdata;
    int         lat;
    int         held;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   cycles;
    int   held;
    bit   seen;
    cycles = 0;
    held   = 0;
    seen   = 1'b0;
    e.done  = v.exp_done;
    e.rdata = v.exp_rdata;
    e.lat   = v.exp_lat;
    e.held  = v.busy + 1;
    sb.push_back(e);
    ch_req = '0;
    ch_req[v.ch] = 1'b1;
    ch_we = '0;
    ch_we[v.ch] = v.we;
    ch_addr[v.ch*ADDR_W +: ADDR_W]  = v.addr;
    ch_wdata[v.ch*DATA_W +: DATA_W] = v.wdata;
    mem_rdata = v.rdata;
    mem_busy  = (v.busy > 0);
    while (!seen && cycles < 40) begin
      step();
      cycles++;
      if (mem_instr != 2'b00) begin
        held++;
        if (held == 1) begin
          chk("vec_instr", 32'(mem_instr), 32'(v.exp_instr));
          chk("vec_addr", 32'(mem_addr), 32'(v.addr));
          chk("vec_wdata", 32'(mem_wdata), 32'(v.wdata));
        end
        mem_busy = (held <= v.busy);
      end
      if (ch_done != '0) seen = 1'b1;
    end
    e = sb.pop_front();
    chk("vec_latency", 32'(cycles), 32'(e.lat));
    chk("vec_done", 32'(ch_done), 32'(e.done));
    chk("vec_rdata", 32'(ch_rdata), 32'(e.rdata));
    chk("vec_cmd_cycles", 32'(held), 32'(e.held));
    ch_req   = '0;
    mem_busy = 1'b0;
    step();
    chk("vec_done_pulse_end", 32'(ch_done), 32'h0);
    chk("vec_bus_idle_after", 32'(mem_instr), 32'h0);
  endtask

  initial begin
    exp_t e;
    vec_t rv;
    int   got;
    int   bad;

    //            ch we addr   wdata  rdata  busy instr  done   rdata  lat
    vecs[0] = '{0, 1, 8'h10, 8'hA5, 8'h00, 0, 2'b10, 2'b01, 8'h00, 3};
    vecs[1] = '{1, 0, 8'h22, 8'h00, 8'h5C, 0, 2'b01, 2'b10, 8'h5C, 5};
    vecs[2] = '{0, 1, 8'h33, 8'h77, 8'hEE, 4, 2'b10, 2'b01, 8'h5C, 7};
    vecs[3] = '{1, 0, 8'h44, 8'h12, 8'hC3, 2, 2'b01, 2'b10, 8'hC3, 7};
    vecs[4] = '{0, 0, 8'hFF, 8'h34, 8'h00, 0, 2'b01, 2'b01, 8'h00, 5};
    vecs[5] = '{1, 1, 8'h01, 8'hFF, 8'h99, 1, 2'b10, 2'b10, 8'h00, 4};

    rst       = 1'b1;
    ch_req    = '0;
    ch_we     = '0;
    ch_addr   = '0;
    ch_wdata  = '0;
    mem_busy  = 1'b0;
    mem_rdata = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_instr", 32'(mem_instr), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_rdata", 32'(ch_rdata), 32'h0);
    chk("rst_done", 32'(ch_done), 32'h0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Fairness: both channels request continuously; grants must alternate starting at ch0.
    for (int k = 0; k < 4; k++) begin
      e.done  = (k % 2 == 0) ? 2'b01 : 2'b10;
      e.rdata = 8'h00;
      e.lat   = 0;
      e.held  = 0;
      sb.push_back(e);
    end
    ch_we    = 2'b11;
    ch_addr  = {8'hB1, 8'hA0};
    ch_wdata = {8'h11, 8'h10};
    ch_req   = 2'b11;
    got = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      step();
      if (ch_done != '0) begin
        e = sb.pop_front();
        chk("fair_grant", 32'(ch_done), 32'(e.done));
        got++;
      end
    end
    ch_req = '0;
    chk("fair_count", 32'(got), 32'd4);
    while (sb.size() > 0) void'(sb.pop_front());
    step();
    chk("fair_idle", 32'(mem_instr), 32'h0);

    // Withdraw: ch0 drops its request while the controller is busy, ch1 is served next.
    mem_busy = 1'b1;
    ch_we    = 2'b11;
    ch_addr  = {8'h66, 8'h55};
    ch_wdata = {8'h06, 8'h05};
    ch_req   = 2'b11;
    step();
    chk("wd_cmd0_instr", 32'(mem_instr), 32'h2);
    chk("wd_cmd0_addr", 32'(mem_addr), 32'h55);
    ch_req = 2'b10;
    step();
    chk("wd_bus_idle", 32'(mem_instr), 32'h0);
    chk("wd_no_done", 32'(ch_done), 32'h0);
    step();
    chk("wd_cmd1_instr", 32'(mem_instr), 32'h2);
    chk("wd_cmd1_addr", 32'(mem_addr), 32'h66);
    mem_busy = 1'b0;
    e.done = 2'b10;
    sb.push_back(e);
    got = 0;
    bad = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      step();
      if (ch_done[0]) bad++;
      if (ch_done != '0) begin
        e = sb.pop_front();
        chk("wd_done", 32'(ch_done), 32'(e.done));
        got++;
      end
    end
    chk("wd_done_seen", 32'(got), 32'd1);
    chk("wd_no_ch0_done", 32'(bad), 32'd0);
    while (sb.size() > 0) void'(sb.pop_front());
    ch_req = '0;
    step();

    // Reset during RD_WAIT: ch0 read completes first (pointer -> 1), then ch1 read is aborted.
    rv = '{0, 0, 8'h12, 8'h00, 8'h3C, 0, 2'b01, 2'b01, 8'h3C, 5};
    run_vec(rv);
    ch_we = 2'b00;
    ch_addr = {8'h2B, 8'h00};
    ch_wdata = {8'h4D, 8'h00};
    mem_rdata = 8'hAB;
    ch_req = 2'b10;
    step();
    chk("rr_read_instr", 32'(mem_instr), 32'h1);
    step();
    rst = 1'b1;
    ch_req = '0;
    step();
    chk("rr_instr", 32'(mem_instr), 32'h0);
    chk("rr_addr", 32'(mem_addr), 32'h0);
    chk("rr_wdata", 32'(mem_wdata), 32'h0);
    chk("rr_rdata", 32'(ch_rdata), 32'h0);
    chk("rr_done", 32'(ch_done), 32'h0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ch_done != '0) bad++;
    end
    chk("rr_no_done_after", 32'(bad), 32'd0);
    // Pointer must be back at 0: with both requesting, ch0 wins.
    ch_we  = 2'b11;
    ch_req = 2'b11;
    e.done = 2'b01;
    sb.push_back(e);
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      step();
      if (ch_done != '0) begin
        e = sb.pop_front();
        chk("rr_ptr_grant", 32'(ch_done), 32'(e.done));
        got++;
      end
    end
    ch_req = '0;
    chk("rr_ptr_seen", 32'(got), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
